// File: rtl/seg7_driver.sv
// Three-digit BCD to 7-segment driver with registered outputs for the microwave time display.
// Optional build macro SEG7_HEX_EN: codes 10..15 show hex glyphs A,b,C,d,E,F instead of blank.
module seg7_driver #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit LZ_BLANK   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       display_en,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] mins,
  output logic [6:0] sec_ones_segs,
  output logic [6:0] sec_tens_segs,
  output logic [6:0] mins_segs
);

  // All segments off, after any common-anode inversion.
  localparam logic [6:0] SegsBlank = ACTIVE_LOW ? 7'h7f : 7'h00;

  // Active-high glyph, bit0=a .. bit6=g.
  function automatic logic [6:0] decode(input logic [3:0] digit);
    logic [6:0] segs;
    segs = 7'h00;
    unique case (digit)
      4'd0:    segs = 7'h3f;
      4'd1:    segs = 7'h06;
      4'd2:    segs = 7'h5b;
      4'd3:    segs = 7'h4f;
      4'd4:    segs = 7'h66;
      4'd5:    segs = 7'h6d;
      4'd6:    segs = 7'h7d;
      4'd7:    segs = 7'h07;
      4'd8:    segs = 7'h7f;
      4'd9:    segs = 7'h6f;
`ifdef SEG7_HEX_EN
      4'd10:   segs = 7'h77;
      4'd11:   segs = 7'h7c;
      4'd12:   segs = 7'h39;
      4'd13:   segs = 7'h5e;
      4'd14:   segs = 7'h79;
      4'd15:   segs = 7'h71;
`else
      default: segs = 7'h00;
`endif
    endcase
    return segs;
  endfunction

  // Blanking and polarity are applied after decode so the glyph table stays active-high.
  function automatic logic [6:0] drive(input logic [3:0] digit, input logic blank);
    logic [6:0] segs;
    segs = blank ? 7'h00 : decode(digit);
    return ACTIVE_LOW ? ~segs : segs;
  endfunction

  logic       mins_blank;
  logic [6:0] sec_ones_segs_d;
  logic [6:0] sec_tens_segs_d;
  logic [6:0] mins_segs_d;

  always_comb begin
    mins_blank      = ~display_en | (LZ_BLANK && (mins == 4'd0));
    sec_ones_segs_d = drive(sec_ones, ~display_en);
    sec_tens_segs_d = drive(sec_tens, ~display_en);
    mins_segs_d     = drive(mins, mins_blank);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_ones_segs <= SegsBlank;
      sec_tens_segs <= SegsBlank;
      mins_segs     <= SegsBlank;
    end else begin
      sec_ones_segs <= sec_ones_segs_d;
      sec_tens_segs <= sec_tens_segs_d;
      mins_segs     <= mins_segs_d;
    end
  end

endmodule

// File: tb/tb_seg7_driver.sv
// Directed self-checking bench for seg7_driver: default, leading-zero-blank and active-low builds.
module tb_seg7_driver;

  logic       clk;
  logic       rst_n;
  logic       display_en;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;

  logic [6:0] so_segs, st_segs, mi_segs;
  logic [6:0] lz_so_segs, lz_st_segs, lz_mi_segs;
  logic [6:0] al_so_segs, al_st_segs, al_mi_segs;

  int checks;
  int failures;

  logic [6:0] dec_tbl [16];

  seg7_driver #(.ACTIVE_LOW(1'b0), .LZ_BLANK(1'b0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .display_en    (display_en),
    .sec_ones      (sec_ones),
    .sec_tens      (sec_tens),
    .mins          (mins),
    .sec_ones_segs (so_segs),
    .sec_tens_segs (st_segs),
    .mins_segs     (mi_segs)
  );

  seg7_driver #(.ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1)) dut_lz (
    .clk           (clk),
    .rst_n         (rst_n),
    .display_en    (display_en),
    .sec_ones      (sec_ones),
    .sec_tens      (sec_tens),
    .mins          (mins),
    .sec_ones_segs (lz_so_segs),
    .sec_tens_segs (lz_st_segs),
    .mins_segs     (lz_mi_segs)
  );

  seg7_driver #(.ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)) dut_al (
    .clk           (clk),
    .rst_n         (rst_n),
    .display_en    (display_en),
    .sec_ones      (sec_ones),
    .sec_tens      (sec_tens),
    .mins          (mins),
    .sec_ones_segs (al_so_segs),
    .sec_tens_segs (al_st_segs),
    .mins_segs     (al_mi_segs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] m, input logic [3:0] t,
                       input logic [3:0] o);
    display_en = en;
    mins       = m;
    sec_tens   = t;
    sec_ones   = o;
  endtask

  initial begin
    dec_tbl = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                7'h7f, 7'h6f, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`ifdef SEG7_HEX_EN
    dec_tbl[10] = 7'h77;
    dec_tbl[11] = 7'h7c;
    dec_tbl[12] = 7'h39;
    dec_tbl[13] = 7'h5e;
    dec_tbl[14] = 7'h79;
    dec_tbl[15] = 7'h71;
`endif
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    drive(1'b1, 4'd8, 4'd8, 4'd8);

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_ones", so_segs, 7'h00);
    check("rst_async_tens", st_segs, 7'h00);
    check("rst_async_mins", mi_segs, 7'h00);
    check("rst_async_al", al_mi_segs, 7'h7f);
    step();
    step();
    check("rst_held_ones", so_segs, 7'h00);
    check("rst_held_al", al_so_segs, 7'h7f);

    // Release between edges: blank until the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_hold", so_segs, 7'h00);
    step();
    check("rst_first_ones", so_segs, 7'h7f);
    check("rst_first_tens", st_segs, 7'h7f);
    check("rst_first_mins", mi_segs, 7'h7f);
    check("rst_first_al", al_mi_segs, 7'h00);

    // Sweep 0..9, one cycle latency, all digits.
    for (int d = 0; d < 10; d++) begin
      drive(1'b1, 4'(d), 4'(d), 4'(d));
      #1;
      if (d > 0) check("latency_hold", so_segs, dec_tbl[d-1]);
      step();
      check($sformatf("sweep_ones_%0d", d), so_segs, dec_tbl[d]);
      check($sformatf("sweep_tens_%0d", d), st_segs, dec_tbl[d]);
      check($sformatf("sweep_mins_%0d", d), mi_segs, dec_tbl[d]);
      check($sformatf("sweep_al_%0d", d), al_so_segs, ~dec_tbl[d]);
    end

    // Independence of digits.
    drive(1'b1, 4'd9, 4'd5, 4'd1);
    step();
    check("indep_ones", so_segs, 7'h06);
    check("indep_tens", st_segs, 7'h6d);
    check("indep_mins", mi_segs, 7'h6f);

    // Codes 10..15 on sec_ones only; other digits must be unaffected.
    for (int d = 10; d < 16; d++) begin
      drive(1'b1, 4'd2, 4'd7, 4'(d));
      step();
      check($sformatf("hex_ones_%0d", d), so_segs, dec_tbl[d]);
      check($sformatf("hex_al_%0d", d), al_so_segs, ~dec_tbl[d]);
      check("hex_tens_indep", st_segs, 7'h07);
      check("hex_mins_indep", mi_segs, 7'h5b);
    end
    drive(1'b1, 4'hc, 4'hf, 4'd4);
    step();
    check("hex_mins_c", mi_segs, dec_tbl[12]);
    check("hex_tens_f", st_segs, dec_tbl[15]);
    check("hex_ones_4", so_segs, 7'h66);

    // Display disable blanks everything.
    drive(1'b0, 4'd3, 4'd3, 4'd3);
    step();
    check("dis_ones", so_segs, 7'h00);
    check("dis_tens", st_segs, 7'h00);
    check("dis_mins", mi_segs, 7'h00);
    check("dis_al", al_st_segs, 7'h7f);
    check("dis_lz_ones", lz_so_segs, 7'h00);

    // Leading-zero blanking of minutes.
    drive(1'b1, 4'd0, 4'd3, 4'd0);
    step();
    check("lz_mins", lz_mi_segs, 7'h00);
    check("lz_tens", lz_st_segs, 7'h4f);
    check("lz_ones", lz_so_segs, 7'h3f);
    check("nolz_mins", mi_segs, 7'h3f);
    check("al_zero", al_mi_segs, 7'h40);
    drive(1'b1, 4'd1, 4'd3, 4'd0);
    step();
    check("lz_mins_nonzero", lz_mi_segs, 7'h06);

    // Reset mid-operation, away from the clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ones", so_segs, 7'h00);
    check("midrst_mins", mi_segs, 7'h00);
    check("midrst_al", al_so_segs, 7'h7f);
    check("midrst_lz", lz_mi_segs, 7'h00);
    #3 rst_n = 1'b1;
    step();
    check("postrst_mins", mi_segs, 7'h06);
    check("postrst_al", al_so_segs, 7'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
